// File: rtl/data_ram_ctrl.sv
// data_ram_ctrl: byte-organised big-endian data RAM with a one-byte-per-cycle
// access sequencer (IDLE -> XFER -> DONE). Loads are zero/sign-extended.
// Optional build macro RAM_ALIGN_CHK_EN: misaligned requests abort instead of
// being silently masked to the access-size alignment.
module data_ram_ctrl #(
    parameter int ADDR_W = 9
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        MFA,
    input  logic [3:0]  CTRL,
    input  logic [31:0] ADDR,
    input  logic [31:0] DATA_IN,
    input  logic [31:0] DATA_IN2,
    output logic [31:0] DATA_OUT,
    output logic [31:0] DATA_OUT2,
    output logic        MOC,
    output logic        BUSY,
    output logic        ABORT
);

    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

    state_t              state_q, state_d;
    logic [3:0]          ctrl_q, ctrl_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [3:0]          nbeat_q, nbeat_d;
    logic [3:0]          beat_q, beat_d;
    logic [63:0]         wdata_q, wdata_d;
    logic [55:0]         asm_q, asm_d;
    logic [31:0]         dout_q, dout_d;
    logic [31:0]         dout2_q, dout2_d;
    logic                abort_q, abort_d;

    logic [7:0]          mem_q [2**ADDR_W];
    logic [ADDR_W-1:0]   cur_addr;
    logic [7:0]          rd_byte;
    logic [63:0]         asm_full;
    logic                mem_we;
    logic                unused_addr_hi;

    assign unused_addr_hi = ^ADDR[31:ADDR_W];

    // Force the base address onto the access-size boundary.
    function automatic logic [ADDR_W-1:0] align_addr(input logic [ADDR_W-1:0] a,
                                                     input logic [1:0] size);
        case (size)
            2'b00:   return a;
            2'b01:   return {a[ADDR_W-1:1], 1'b0};
            default: return {a[ADDR_W-1:2], 2'b00};
        endcase
    endfunction

    // Left-justify store data so the byte to write is always in [63:56].
    function automatic logic [63:0] pack_store(input logic [31:0] d1,
                                               input logic [31:0] d2,
                                               input logic [1:0]  size);
        case (size)
            2'b00:   return {d1[7:0], 56'h0};
            2'b01:   return {d1[15:0], 48'h0};
            2'b10:   return {d1, 32'h0};
            default: return {d1, d2};
        endcase
    endfunction

    // First load word with zero/sign extension for sub-word sizes.
    function automatic logic [31:0] ext_load(input logic [63:0] a,
                                             input logic [1:0]  size,
                                             input logic        sx);
        case (size)
            2'b00:   return sx ? {{24{a[7]}}, a[7:0]}   : {24'h0, a[7:0]};
            2'b01:   return sx ? {{16{a[15]}}, a[15:0]} : {16'h0, a[15:0]};
            2'b10:   return a[31:0];
            default: return a[63:32];
        endcase
    endfunction

`ifdef RAM_ALIGN_CHK_EN
    logic misalign;
    assign misalign = ((CTRL[1:0] == 2'b01) && ADDR[0]) || (CTRL[1] && (ADDR[1:0] != 2'b00));
    assign ABORT    = (state_q == DONE) && abort_q;
`else
    assign ABORT    = 1'b0;
`endif

    assign cur_addr  = base_q + ADDR_W'(beat_q);
    assign rd_byte   = mem_q[cur_addr];
    assign asm_full  = {asm_q, rd_byte};
    assign DATA_OUT  = dout_q;
    assign DATA_OUT2 = dout2_q;
    assign BUSY      = (state_q != IDLE);
    assign MOC       = (state_q == DONE) && !abort_q;

    // Next-state, beat sequencing, read assembly and write strobe.
    always_comb begin
        state_d = state_q;
        ctrl_d  = ctrl_q;
        base_d  = base_q;
        nbeat_d = nbeat_q;
        beat_d  = beat_q;
        wdata_d = wdata_q;
        asm_d   = asm_q;
        dout_d  = dout_q;
        dout2_d = dout2_q;
        abort_d = abort_q;
        mem_we  = 1'b0;
        case (state_q)
            IDLE: begin
                if (MFA) begin
                    ctrl_d  = CTRL;
                    base_d  = align_addr(ADDR[ADDR_W-1:0], CTRL[1:0]);
                    nbeat_d = 4'd1 << CTRL[1:0];
                    beat_d  = 4'd0;
                    wdata_d = pack_store(DATA_IN, DATA_IN2, CTRL[1:0]);
                    asm_d   = 56'h0;
                    abort_d = 1'b0;
`ifdef RAM_ALIGN_CHK_EN
                    // A misaligned request spends one dead beat so ABORT
                    // lands with the same timing as a byte access.
                    if (misalign) begin
                        abort_d = 1'b1;
                        nbeat_d = 4'd1;
                    end
`endif
                    state_d = XFER;
                end
            end
            XFER: begin
                if (!abort_q) begin
                    if (ctrl_q[3]) asm_d = asm_full[55:0];
                    else           mem_we = 1'b1;
                end
                wdata_d = {wdata_q[55:0], 8'h0};
                beat_d  = beat_q + 4'd1;
                if (beat_q == nbeat_q - 4'd1) begin
                    state_d = DONE;
                    if (ctrl_q[3] && !abort_q) begin
                        dout_d  = ext_load(asm_full, ctrl_q[1:0], ctrl_q[2]);
                        dout2_d = (ctrl_q[1:0] == 2'b11) ? asm_full[31:0] : 32'h0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and read-result registers; reset returns to IDLE with outputs cleared.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            beat_q  <= 4'd0;
            nbeat_q <= 4'd1;
            abort_q <= 1'b0;
            dout_q  <= 32'h0;
            dout2_q <= 32'h0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            nbeat_q <= nbeat_d;
            abort_q <= abort_d;
            dout_q  <= dout_d;
            dout2_q <= dout2_d;
        end
    end

    // Latched request data; not reset, only meaningful once a request is accepted.
    always_ff @(posedge CLK) begin
        ctrl_q  <= ctrl_d;
        base_q  <= base_d;
        wdata_q <= wdata_d;
        asm_q   <= asm_d;
    end

    // Byte-wide memory array; a reset cycle suppresses the pending write.
    always_ff @(posedge CLK) begin
        if (mem_we && !RESET) mem_q[cur_addr] <= wdata_q[63:56];
    end

endmodule

// File: tb/tb_data_ram_ctrl.sv
// Directed self-checking bench for data_ram_ctrl (default build, ADDR_W=9).
module tb_data_ram_ctrl;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        MFA = 1'b0;
    logic [3:0]  CTRL = 4'h0;
    logic [31:0] ADDR = 32'h0;
    logic [31:0] DATA_IN = 32'h0;
    logic [31:0] DATA_IN2 = 32'h0;
    logic [31:0] DATA_OUT, DATA_OUT2;
    logic        MOC, BUSY, ABORT;

    int n_chk = 0;
    int n_pass = 0;
    int lat;

    data_ram_ctrl #(.ADDR_W(9)) dut (
        .CLK(CLK), .RESET(RESET), .MFA(MFA), .CTRL(CTRL), .ADDR(ADDR),
        .DATA_IN(DATA_IN), .DATA_IN2(DATA_IN2), .DATA_OUT(DATA_OUT),
        .DATA_OUT2(DATA_OUT2), .MOC(MOC), .BUSY(BUSY), .ABORT(ABORT)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // One MFA pulse; returns the cycle (counted from acceptance) in which MOC is seen.
    // With inject set, a conflicting byte-write request is pulsed while busy.
    task automatic access(input logic [3:0] ctrl, input logic [31:0] addr,
                          input logic [31:0] d1, input logic [31:0] d2,
                          input bit inject, output int l);
        @(negedge CLK);
        MFA = 1'b1; CTRL = ctrl; ADDR = addr; DATA_IN = d1; DATA_IN2 = d2;
        @(negedge CLK);
        MFA = 1'b0;
        l = -1;
        for (int k = 1; k <= 20; k++) begin
            if (k > 1) @(negedge CLK);
            if (inject && k == 2) begin
                MFA = 1'b1; CTRL = 4'b0000; ADDR = 32'h10; DATA_IN = 32'hFF;
            end else if (inject && k == 3) begin
                MFA = 1'b0;
            end
            if (MOC) begin
                l = k;
                break;
            end
        end
    endtask

    initial begin
        logic saw;
        logic [31:0] moc_pat;
        // reset state
        repeat (3) @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        check("rst_moc", {31'h0, MOC}, 32'h0);
        check("rst_busy", {31'h0, BUSY}, 32'h0);
        check("rst_abort", {31'h0, ABORT}, 32'h0);
        check("rst_dout", DATA_OUT, 32'h0);
        check("rst_dout2", DATA_OUT2, 32'h0);

        // word write / read / byte read
        access(4'b0010, 32'h010, 32'h11223344, 32'h0, 1'b0, lat);
        check("w_wr_lat", lat, 32'd5);
        access(4'b1010, 32'h010, 32'h0, 32'h0, 1'b0, lat);
        check("w_rd_lat", lat, 32'd5);
        check("w_rd", DATA_OUT, 32'h11223344);
        check("w_rd2", DATA_OUT2, 32'h0);
        access(4'b1000, 32'h010, 32'h0, 32'h0, 1'b0, lat);
        check("b_rd_lat", lat, 32'd2);
        check("b_rd", DATA_OUT, 32'h00000011);

        // byte sign/zero extension; write leaves DATA_OUT unchanged
        access(4'b0000, 32'h021, 32'h00000080, 32'h0, 1'b0, lat);
        check("b_wr_keep", DATA_OUT, 32'h00000011);
        access(4'b1100, 32'h021, 32'h0, 32'h0, 1'b0, lat);
        check("b_sx", DATA_OUT, 32'hFFFFFF80);
        access(4'b1000, 32'h021, 32'h0, 32'h0, 1'b0, lat);
        check("b_zx", DATA_OUT, 32'h00000080);

        // halfword
        access(4'b0001, 32'h030, 32'h00008001, 32'h0, 1'b0, lat);
        access(4'b1101, 32'h030, 32'h0, 32'h0, 1'b0, lat);
        check("h_lat", lat, 32'd3);
        check("h_sx", DATA_OUT, 32'hFFFF8001);
        access(4'b1001, 32'h030, 32'h0, 32'h0, 1'b0, lat);
        check("h_zx", DATA_OUT, 32'h00008001);

        // doubleword, then wrap at top of memory
        access(4'b0011, 32'h1F8, 32'hAAAA5555, 32'h12345678, 1'b0, lat);
        check("d_wr_lat", lat, 32'd9);
        access(4'b1011, 32'h1F8, 32'h0, 32'h0, 1'b0, lat);
        check("d_rd_lat", lat, 32'd9);
        check("d_rd1", DATA_OUT, 32'hAAAA5555);
        check("d_rd2", DATA_OUT2, 32'h12345678);
        access(4'b0011, 32'h1FC, 32'h01020304, 32'hCAFEBABE, 1'b0, lat);
        access(4'b1011, 32'h1FC, 32'h0, 32'h0, 1'b0, lat);
        check("dw_rd1", DATA_OUT, 32'h01020304);
        check("dw_rd2", DATA_OUT2, 32'hCAFEBABE);
        access(4'b1010, 32'h000, 32'h0, 32'h0, 1'b0, lat);
        check("dw_wrap0", DATA_OUT, 32'hCAFEBABE);
        check("w_rd2_zero", DATA_OUT2, 32'h0);

        // reset during the 3rd XFER beat of a word write
        access(4'b0010, 32'h040, 32'h0, 32'h0, 1'b0, lat);
        @(negedge CLK);
        MFA = 1'b1; CTRL = 4'b0010; ADDR = 32'h040; DATA_IN = 32'hDEADBEEF;
        @(negedge CLK);
        MFA = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        check("mid_rst_busy", {31'h0, BUSY}, 32'h0);
        check("mid_rst_moc", {31'h0, MOC}, 32'h0);
        check("mid_rst_dout", DATA_OUT, 32'h0);
        saw = 1'b0;
        repeat (6) begin
            @(negedge CLK);
            saw = saw | MOC;
        end
        check("mid_rst_nomoc", {31'h0, saw}, 32'h0);
        access(4'b1001, 32'h040, 32'h0, 32'h0, 1'b0, lat);
        check("mid_rst_h", DATA_OUT, 32'h0000DEAD);
        access(4'b1001, 32'h042, 32'h0, 32'h0, 1'b0, lat);
        check("mid_rst_h2", DATA_OUT, 32'h0);

        // RESET and MFA together: request dropped
        @(negedge CLK);
        RESET = 1'b1; MFA = 1'b1; CTRL = 4'b1010; ADDR = 32'h010;
        @(negedge CLK);
        RESET = 1'b0; MFA = 1'b0;
        check("rst_mfa_busy", {31'h0, BUSY}, 32'h0);

        // MFA during BUSY ignored
        access(4'b1010, 32'h010, 32'h0, 32'h0, 1'b1, lat);
        check("ign_lat", lat, 32'd5);
        check("ign_rd", DATA_OUT, 32'h11223344);
        saw = 1'b0;
        repeat (4) begin
            @(negedge CLK);
            saw = saw | MOC;
        end
        check("ign_nomoc", {31'h0, saw}, 32'h0);
        access(4'b1000, 32'h010, 32'h0, 32'h0, 1'b0, lat);
        check("ign_mem", DATA_OUT, 32'h00000011);

        // misaligned word write masked to 0x040
        access(4'b0010, 32'h042, 32'hCAFEF00D, 32'h0, 1'b0, lat);
        check("mis_lat", lat, 32'd5);
        check("mis_abort", {31'h0, ABORT}, 32'h0);
        access(4'b1010, 32'h040, 32'h0, 32'h0, 1'b0, lat);
        check("mis_rd", DATA_OUT, 32'hCAFEF00D);

        // MFA held high: back-to-back byte reads, MOC every 3 cycles
        @(negedge CLK);
        MFA = 1'b1; CTRL = 4'b1000; ADDR = 32'h010;
        moc_pat = 32'h0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge CLK);
            moc_pat[k] = MOC;
        end
        MFA = 1'b0;
        check("b2b_moc", moc_pat, 32'h00000024);
        repeat (4) @(negedge CLK);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
